mc_control_gen: RTL and testbench
=================================

# mc_control_gen

Parametrised multi-cycle control unit for the FRISCV core; successor of the fixed five-state sequencer. Drives datapath selects/enables from a RESET/FETCH/DECODE/COMPUTE/MEM/WB/TRAP machine with opcode-dependent paths, a memory request/acknowledge handshake with timeout, an external stall, branch/jump PC control, illegal-opcode trapping and a retired-instruction counter. Sits between the IR and the PC/RF/ALU/memory muxes.

## Interface
- TIMEOUT, 16, max consecutive unacknowledged request cycles in FETCH/MEM before trap; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ins  in  32  instruction from the IR; valid from DECODE onward.
- stall  in  1  freezes the machine while high.
- mem_ack  in  1  memory acknowledge for the current request.
- br_taken  in  1  ALU branch-compare result; sampled in COMPUTE.
- mem_req  out  1  memory request (fetch or data).
- mem_we  out  1  data write; STORE in MEM only.
- PC_sel  out  2  00 = PC+4, 01 = ALU target (PC-relative), 10 = ALU result & ~1 (JALR).
- PC_en, IR_en, INC_sel, RF_wr, B_sel  out  1 each  datapath enables/selects.
- Extend  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- wb_sel  out  2  RF write source: 00 = ALU, 01 = memory, 10 = PC+4.
- trap  out  1  sticky trap indication.
- err  out  2  00 = none, 01 = illegal opcode, 10 = fetch timeout, 11 = memory timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Classes from ins[6:0]: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- RESET -> FETCH unconditionally.
- FETCH:
  - mem_req=1.
  - On mem_ack: IR_en=1, PC_en=1, PC_sel=00, then -> DECODE.
  - Otherwise hold.
- DECODE: legal opcode -> COMPUTE; illegal -> TRAP with err=01.
- COMPUTE:
  - INC_sel=1. B_sel=0 for R and BRANCH, 1 otherwise.
  - LOAD/STORE -> MEM.
  - BRANCH: PC_en=br_taken, PC_sel=01, retire, -> FETCH.
  - JAL: PC_en=1, PC_sel=01. JALR: PC_en=1, PC_sel=10.
  - All others -> WB.
- MEM:
  - mem_req=1, mem_we=(STORE).
  - On mem_ack: LOAD -> WB; STORE -> retire, -> FETCH.
  - Otherwise hold.
- WB:
  - RF_wr=1 (R, I, LOAD, JAL, JALR, LUI, AUIPC).
  - wb_sel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - Retire, -> FETCH.
- TRAP: absorbing until rst_n. All enables 0, mem_req=0, trap=1, err held.
- Extend:
  - Driven from class in DECODE/COMPUTE/MEM/WB: I for I/LOAD/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 000 for R.
  - 000 in RESET/FETCH/TRAP.
- Output decode is combinational from state, class, mem_ack and br_taken.
- mem_req never depends on mem_ack (no combinational loop).
- Retire: instret += 1, wrapping modulo 2^CNT_W.
- Timeout:
  - Counter cleared on entry to FETCH/MEM; increments each unacknowledged request cycle.
  - On the TIMEOUT-th consecutive unacked cycle -> TRAP with err 10 (FETCH) or 11 (MEM).
  - An ack in that same cycle wins: no trap.
  - TIMEOUT=0 disables the timeout.
- Stall:
  - While stall=1: state, timeout counter and instret hold.
  - PC_en, IR_en, RF_wr, mem_req and mem_we are forced 0; mem_ack is ignored.
  - Stall in TRAP has no effect.

## Timing
- Reset (async, immediate):
  - state=RESET, instret=0, err=00, trap=0, timeout counter=0.
  - All enables 0, mem_req=0, PC_sel=00, Extend=000, wb_sel=00, B_sel=1, INC_sel=0.
- Zero-wait-state latencies (mem_ack=1 in the first request cycle):
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles. STORE: 4 cycles. BRANCH: 3 cycles.
- Each extra wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- mem_ack outside FETCH/MEM is ignored.
- rst_n asserted mid-instruction aborts it; no partial retire is counted.

## Test plan
- Reset, then ADD (0x003100B3) with ack every request -> FETCH, DECODE, COMPUTE (B_sel=0), WB (RF_wr=1, wb_sel=00); instret=1 after 4 cycles.
- LW (0x0000A083) with ack delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0, then WB with wb_sel=01; total 8 cycles.
- BEQ (0x00208463): br_taken=1 -> PC_en=1, PC_sel=01, Extend=010 in COMPUTE. br_taken=0 -> PC_en=0. instret +1 both cases, no WB.
- Opcode 0x0000007F -> TRAP after DECODE, err=01, trap=1; a later mem_ack causes no change until rst_n.
- TIMEOUT=4, mem_ack never asserted in FETCH -> TRAP on the 4th request cycle, err=10. Repeat with ack on the 4th cycle -> DECODE, no trap.
- stall=1 for 5 cycles mid-MEM of SW -> mem_req=0, state held; release then ack -> mem_we=1 for 1 cycle, instret +1.

Source files
------------

// File: rtl/mc_control_gen.sv
// Multi-cycle control unit for the FRISCV core: sequences FETCH/DECODE/COMPUTE/MEM/WB,
// drives datapath selects and the memory handshake, traps on illegal opcodes or timeouts.
module mc_control_gen #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             stall,
    input  logic             mem_ack,
    input  logic             br_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       PC_sel,
    output logic             PC_en,
    output logic             IR_en,
    output logic             INC_sel,
    output logic             RF_wr,
    output logic             B_sel,
    output logic [2:0]       Extend,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_COMPUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC,
        CL_ILL
    } class_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_FETCH_TO = 2'b10,
        ERR_MEM_TO   = 2'b11
    } err_e;

    // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th unacked cycle is the trap cycle.
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e          state;
    class_e          cls;
    err_e            err_q;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            ins_unused;

    assign ins_unused = ^ins[31:7];
    assign err        = err_q;
    assign to_hit     = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_comb begin
        cls = CL_ILL;
        unique case (ins[6:0])
            7'b0110011: cls = CL_R;
            7'b0010011: cls = CL_I;
            7'b0000011: cls = CL_LOAD;
            7'b0100011: cls = CL_STORE;
            7'b1100011: cls = CL_BRANCH;
            7'b1101111: cls = CL_JAL;
            7'b1100111: cls = CL_JALR;
            7'b0110111: cls = CL_LUI;
            7'b0010111: cls = CL_AUIPC;
            default:    cls = CL_ILL;
        endcase
    end

    function automatic logic [2:0] ext_of(input class_e c);
        logic [2:0] e;
        e = 3'b000;
        unique case (c)
            CL_I, CL_LOAD, CL_JALR: e = 3'b000;
            CL_STORE:               e = 3'b001;
            CL_BRANCH:              e = 3'b010;
            CL_LUI, CL_AUIPC:       e = 3'b011;
            CL_JAL:                 e = 3'b100;
            default:                e = 3'b000;
        endcase
        return e;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            instret <= '0;
            err_q   <= ERR_NONE;
            trap    <= 1'b0;
            to_cnt  <= '0;
        end else if (!stall) begin
            // Cleared on every cycle that is not an unacked request hold, so it restarts on entry.
            to_cnt <= '0;
            unique case (state)
                ST_RESET: state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ack) begin
                        state <= ST_DECODE;
                    end else if (to_hit) begin
                        state <= ST_TRAP;
                        trap  <= 1'b1;
                        err_q <= ERR_FETCH_TO;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (cls == CL_ILL) begin
                        state <= ST_TRAP;
                        trap  <= 1'b1;
                        err_q <= ERR_ILLEGAL;
                    end else begin
                        state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    unique case (cls)
                        CL_LOAD, CL_STORE: state <= ST_MEM;
                        CL_BRANCH: begin
                            state   <= ST_FETCH;
                            instret <= instret + CNT_W'(1);
                        end
                        default: state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (cls == CL_STORE) begin
                            state   <= ST_FETCH;
                            instret <= instret + CNT_W'(1);
                        end else begin
                            state <= ST_WB;
                        end
                    end else if (to_hit) begin
                        state <= ST_TRAP;
                        trap  <= 1'b1;
                        err_q <= ERR_MEM_TO;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_WB: begin
                    state   <= ST_FETCH;
                    instret <= instret + CNT_W'(1);
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        PC_sel  = 2'b00;
        PC_en   = 1'b0;
        IR_en   = 1'b0;
        INC_sel = 1'b0;
        RF_wr   = 1'b0;
        B_sel   = 1'b1;
        Extend  = 3'b000;
        wb_sel  = 2'b00;
        unique case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    IR_en = 1'b1;
                    PC_en = 1'b1;
                end
            end
            ST_DECODE: Extend = ext_of(cls);
            ST_COMPUTE: begin
                Extend  = ext_of(cls);
                INC_sel = 1'b1;
                B_sel   = !(cls == CL_R || cls == CL_BRANCH);
                unique case (cls)
                    CL_BRANCH: begin
                        PC_en  = br_taken;
                        PC_sel = 2'b01;
                    end
                    CL_JAL: begin
                        PC_en  = 1'b1;
                        PC_sel = 2'b01;
                    end
                    CL_JALR: begin
                        PC_en  = 1'b1;
                        PC_sel = 2'b10;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                Extend  = ext_of(cls);
                mem_req = 1'b1;
                mem_we  = (cls == CL_STORE);
            end
            ST_WB: begin
                Extend = ext_of(cls);
                RF_wr  = 1'b1;
                if (cls == CL_LOAD)
                    wb_sel = 2'b01;
                else if (cls == CL_JAL || cls == CL_JALR)
                    wb_sel = 2'b10;
            end
            default: ;
        endcase
        if (stall) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            PC_en   = 1'b0;
            IR_en   = 1'b0;
            RF_wr   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_gen.sv
// Scoreboard bench for mc_control_gen: per-cycle expected controls and instret are queued
// as stimulus is applied and compared mid-cycle against the DUT outputs.
module tb_mc_control_gen;

    localparam int unsigned CW = 4;

    // Packed view: {req, we, PC_sel, PC_en, IR_en, INC_sel, RF_wr, B_sel, Extend, wb_sel, trap, err}
    localparam logic [16:0] M_REQ   = 17'h10000;
    localparam logic [16:0] M_WE    = 17'h08000;
    localparam logic [16:0] PS_REL  = 17'h02000;
    localparam logic [16:0] PS_JALR = 17'h04000;
    localparam logic [16:0] M_PCEN  = 17'h01000;
    localparam logic [16:0] M_IREN  = 17'h00800;
    localparam logic [16:0] M_INC   = 17'h00400;
    localparam logic [16:0] M_RFWR  = 17'h00200;
    localparam logic [16:0] M_BSEL  = 17'h00100;
    localparam logic [16:0] EX_S    = 17'h00020;
    localparam logic [16:0] EX_B    = 17'h00040;
    localparam logic [16:0] EX_U    = 17'h00060;
    localparam logic [16:0] EX_J    = 17'h00080;
    localparam logic [16:0] WB_MEM  = 17'h00008;
    localparam logic [16:0] WB_PC   = 17'h00010;
    localparam logic [16:0] M_TRAP  = 17'h00004;
    localparam logic [16:0] ER_ILL  = 17'h00001;
    localparam logic [16:0] ER_FTO  = 17'h00002;
    localparam logic [16:0] ER_MTO  = 17'h00003;
    localparam logic [16:0] FETCH_OK = M_REQ | M_IREN | M_PCEN | M_BSEL;

    logic          clk, rst_n, stall, mem_ack, br_taken;
    logic [31:0]   ins;
    logic          mem_req, mem_we, PC_en, IR_en, INC_sel, RF_wr, B_sel, trap;
    logic [1:0]    PC_sel, wb_sel, err;
    logic [2:0]    Extend;
    logic [CW-1:0] instret;

    typedef struct {
        string         tag;
        logic [16:0]   ctl;
        logic [CW-1:0] ir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ret  = 0;

    mc_control_gen #(.TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .stall(stall), .mem_ack(mem_ack),
        .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we), .PC_sel(PC_sel),
        .PC_en(PC_en), .IR_en(IR_en), .INC_sel(INC_sel), .RF_wr(RF_wr), .B_sel(B_sel),
        .Extend(Extend), .wb_sel(wb_sel), .trap(trap), .err(err), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] snap();
        return {mem_req, mem_we, PC_sel, PC_en, IR_en, INC_sel, RF_wr, B_sel,
                Extend, wb_sel, trap, err};
    endfunction

    task automatic push(input string tag, input logic [16:0] ctl);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.ir  = CW'(n_ret);
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_ctl"}, 32'(snap()), 32'(e.ctl));
        check({e.tag, "_instret"}, 32'(instret), 32'(e.ir));
    endtask

    // Entered and left at posedge+1; outputs compared on the falling edge.
    task automatic step(input string tag, input logic st, input logic ack, input logic br,
                        input logic [16:0] ctl, input bit retire);
        stall    = st;
        mem_ack  = ack;
        br_taken = br;
        push(tag, ctl);
        if (retire) n_ret++;
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        stall    = 1'b0;
        mem_ack  = 1'b0;
        br_taken = 1'b0;
        n_ret    = 0;
        #1;
        push({tag, "_async"}, M_BSEL);
        compare_front();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step({tag, "_rst_state"}, 1'b0, 1'b1, 1'b0, M_BSEL, 1'b0);
    endtask

    task automatic run_beq(input string tag, input logic br);
        ins = 32'h00208463;
        step({tag, "_fetch"}, 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step({tag, "_dec"}, 1'b0, 1'b0, br, M_BSEL | EX_B, 1'b0);
        step({tag, "_cmp"}, 1'b0, 1'b0, br,
             M_INC | EX_B | PS_REL | (br ? M_PCEN : 17'h0), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
        ins = 32'h003100B3;
        @(posedge clk);
        #1;
        do_reset("por");

        // ADD, with mem_ack held high outside FETCH to show it is ignored
        step("add_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("add_dec", 1'b0, 1'b1, 1'b0, M_BSEL, 1'b0);
        step("add_cmp", 1'b0, 1'b1, 1'b0, M_INC, 1'b0);
        step("add_wb", 1'b0, 1'b1, 1'b0, M_RFWR | M_BSEL, 1'b1);

        // LW with three wait cycles in MEM
        ins = 32'h0000A083;
        step("lw_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("lw_dec", 1'b0, 1'b0, 1'b0, M_BSEL, 1'b0);
        step("lw_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL, 1'b0);
        for (int i = 0; i < 3; i++)
            step("lw_mem_wait", 1'b0, 1'b0, 1'b0, M_REQ | M_BSEL, 1'b0);
        step("lw_mem_ack", 1'b0, 1'b1, 1'b0, M_REQ | M_BSEL, 1'b0);
        step("lw_wb", 1'b0, 1'b0, 1'b0, M_RFWR | M_BSEL | WB_MEM, 1'b1);

        run_beq("beq_t", 1'b1);
        run_beq("beq_nt", 1'b0);

        // SW stalled mid-MEM; acks during the stall must be ignored
        ins = 32'h0020A023;
        step("sw_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("sw_dec", 1'b0, 1'b0, 1'b0, M_BSEL | EX_S, 1'b0);
        step("sw_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL | EX_S, 1'b0);
        for (int i = 0; i < 2; i++)
            step("sw_mem_wait", 1'b0, 1'b0, 1'b0, M_REQ | M_WE | M_BSEL | EX_S, 1'b0);
        for (int i = 0; i < 5; i++)
            step("sw_stall", 1'b1, 1'b1, 1'b0, M_BSEL | EX_S, 1'b0);
        step("sw_mem_ack", 1'b0, 1'b1, 1'b0, M_REQ | M_WE | M_BSEL | EX_S, 1'b1);

        // JAL: fetch ack lands on the 4th unacked request cycle, one stall cycle in between
        ins = 32'h008000EF;
        for (int i = 0; i < 2; i++)
            step("jal_fetch_wait", 1'b0, 1'b0, 1'b0, M_REQ | M_BSEL, 1'b0);
        step("jal_fetch_stall", 1'b1, 1'b1, 1'b0, M_BSEL, 1'b0);
        step("jal_fetch_wait3", 1'b0, 1'b0, 1'b0, M_REQ | M_BSEL, 1'b0);
        step("jal_fetch_ack4", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("jal_dec", 1'b0, 1'b0, 1'b0, M_BSEL | EX_J, 1'b0);
        step("jal_cmp_stall", 1'b1, 1'b0, 1'b0, M_INC | M_BSEL | EX_J | PS_REL, 1'b0);
        step("jal_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL | EX_J | PS_REL | M_PCEN, 1'b0);
        step("jal_wb", 1'b0, 1'b0, 1'b0, M_RFWR | M_BSEL | EX_J | WB_PC, 1'b1);

        ins = 32'h000080E7;
        step("jalr_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("jalr_dec", 1'b0, 1'b0, 1'b0, M_BSEL, 1'b0);
        step("jalr_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL | PS_JALR | M_PCEN, 1'b0);
        step("jalr_wb", 1'b0, 1'b0, 1'b0, M_RFWR | M_BSEL | WB_PC, 1'b1);

        ins = 32'h123450B7;
        step("lui_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("lui_dec", 1'b0, 1'b0, 1'b0, M_BSEL | EX_U, 1'b0);
        step("lui_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL | EX_U, 1'b0);
        step("lui_wb_stall", 1'b1, 1'b0, 1'b0, M_BSEL | EX_U, 1'b0);
        step("lui_wb", 1'b0, 1'b0, 1'b0, M_RFWR | M_BSEL | EX_U, 1'b1);

        // Eight more retires wrap the 4-bit counter through zero
        for (int k = 0; k < 8; k++)
            run_beq("beq_wrap", 1'b0);

        ins = 32'h00108093;
        step("addi_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("addi_dec", 1'b0, 1'b0, 1'b0, M_BSEL, 1'b0);
        step("addi_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL, 1'b0);
        step("addi_wb", 1'b0, 1'b0, 1'b0, M_RFWR | M_BSEL, 1'b1);

        ins = 32'h0000007F;
        step("ill_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("ill_dec", 1'b0, 1'b0, 1'b0, M_BSEL, 1'b0);
        for (int i = 0; i < 4; i++)
            step("ill_trap", 1'(i % 2), 1'b1, 1'b1, M_BSEL | M_TRAP | ER_ILL, 1'b0);

        do_reset("rst2");
        for (int i = 0; i < 4; i++)
            step("fto_wait", 1'b0, 1'b0, 1'b0, M_REQ | M_BSEL, 1'b0);
        for (int i = 0; i < 2; i++)
            step("fto_trap", 1'b0, 1'b1, 1'b0, M_BSEL | M_TRAP | ER_FTO, 1'b0);

        do_reset("rst3");
        ins = 32'h0000A083;
        step("mto_fetch", 1'b0, 1'b1, 1'b0, FETCH_OK, 1'b0);
        step("mto_dec", 1'b0, 1'b0, 1'b0, M_BSEL, 1'b0);
        step("mto_cmp", 1'b0, 1'b0, 1'b0, M_INC | M_BSEL, 1'b0);
        for (int i = 0; i < 4; i++)
            step("mto_wait", 1'b0, 1'b0, 1'b0, M_REQ | M_BSEL, 1'b0);
        step("mto_trap", 1'b0, 1'b1, 1'b0, M_BSEL | M_TRAP | ER_MTO, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
